cgra_io_streamer: RTL and testbench

- Synthesizable replacement for the off-chip stream driver/capture logic on the CGRA's user I/O.
- Buffers host-supplied input words in a FIFO and emits a one-cycle start pulse on the CGRA's 1-bit input.
- Then drives a free-running stream of num_words words on the CGRA's data inputs, one word per cycle, with no backpressure.
- Captures valid-qualified CGRA outputs into a second FIFO for host readout.
- Generalises the single 16-bit stream to NUM_CH channels of DATA_W bits, with run-length, drain window and error flags.

---
 rtl/cgra_io_streamer.sv | 228 ++++++++++++++++++++++
 tb/tb_cgra_io_streamer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cgra_io_streamer.sv
// CGRA user-I/O stream engine: buffers host words, issues a start pulse, streams
// a fixed-length run onto the CGRA inputs and captures valid-qualified outputs.

module cgra_io_streamer_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_acc;
  logic          pop_acc;

  assign full_o   = (count_q == (AW+1)'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign pop_acc  = pop_i && !empty_o;
  // A push into a full FIFO is still taken when the head leaves in the same cycle.
  assign push_acc = push_i && (!full_o || pop_acc);
  assign head_o   = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push_acc) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_acc) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_acc) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_acc, pop_acc})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

module cgra_io_streamer #(
  parameter int DATA_W       = 16,
  parameter int NUM_CH       = 1,
  parameter int FIFO_DEPTH   = 8,
  parameter int LEN_W        = 16,
  parameter int DRAIN_CYCLES = 64
) (
  input  logic                     io_clock,
  input  logic                     io_reset,
  input  logic                     start,
  input  logic [LEN_W-1:0]         num_words,
  input  logic                     src_valid,
  input  logic [NUM_CH*DATA_W-1:0] src_data,
  output logic                     src_ready,
  output logic [NUM_CH*DATA_W-1:0] glb2io_data,
  output logic                     glb2io_start,
  input  logic [NUM_CH*DATA_W-1:0] io2glb_data,
  input  logic [NUM_CH-1:0]        io2glb_valid,
  output logic                     snk_valid,
  output logic [NUM_CH*DATA_W-1:0] snk_data,
  output logic [NUM_CH-1:0]        snk_valid_mask,
  input  logic                     snk_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     underrun,
  output logic                     overflow,
  output logic [LEN_W-1:0]         out_count
);
  localparam int WW = NUM_CH * DATA_W;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t            state_q;
  logic [LEN_W-1:0]  remaining_q;
  logic [DW-1:0]     drain_cnt_q;
  logic [WW-1:0]     glb2io_data_q;
  logic              glb2io_start_q;
  logic              done_q;
  logic              underrun_q;
  logic              overflow_q;
  logic [LEN_W-1:0]  out_count_q;

  logic              in_full;
  logic              in_empty;
  logic [WW-1:0]     in_head;
  logic              out_full;
  logic              out_empty;
  logic [WW+NUM_CH-1:0] out_head;
  logic              issue_word;
  logic              capture_try;
  logic              snk_pop;

  // remaining counts words not yet issued, so each STREAM cycle shows one word.
  assign issue_word  = ((state_q == S_START) || (state_q == S_STREAM)) && (remaining_q != '0);
  assign capture_try = ((state_q == S_STREAM) || (state_q == S_DRAIN)) && (|io2glb_valid);
  assign snk_pop     = snk_ready && !out_empty;

  cgra_io_streamer_fifo #(
    .W     (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_in_fifo (
    .clk_i       (io_clock),
    .rst_i       (io_reset),
    .push_i      (src_valid),
    .push_data_i (src_data),
    .pop_i       (issue_word),
    .head_o      (in_head),
    .full_o      (in_full),
    .empty_o     (in_empty)
  );

  cgra_io_streamer_fifo #(
    .W     (WW + NUM_CH),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk_i       (io_clock),
    .rst_i       (io_reset),
    .push_i      (capture_try),
    .push_data_i ({io2glb_data, io2glb_valid}),
    .pop_i       (snk_pop),
    .head_o      (out_head),
    .full_o      (out_full),
    .empty_o     (out_empty)
  );

  always_ff @(posedge io_clock or posedge io_reset) begin
    if (io_reset) begin
      state_q        <= S_IDLE;
      remaining_q    <= '0;
      drain_cnt_q    <= '0;
      glb2io_data_q  <= '0;
      glb2io_start_q <= 1'b0;
      done_q         <= 1'b0;
      underrun_q     <= 1'b0;
      overflow_q     <= 1'b0;
      out_count_q    <= '0;
    end else begin
      glb2io_start_q <= 1'b0;
      done_q         <= 1'b0;
      glb2io_data_q  <= '0;

      // The stream is time-based: an empty FIFO still consumes a slot.
      if (issue_word) begin
        glb2io_data_q <= in_empty ? '0 : in_head;
        remaining_q   <= remaining_q - LEN_W'(1);
        if (in_empty) begin
          underrun_q <= 1'b1;
        end
      end

      if (capture_try) begin
        if (out_count_q != '1) begin
          out_count_q <= out_count_q + LEN_W'(1);
        end
        if (out_full && !snk_pop) begin
          overflow_q <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            remaining_q    <= num_words;
            underrun_q     <= 1'b0;
            overflow_q     <= 1'b0;
            out_count_q    <= '0;
            glb2io_start_q <= 1'b1;
            state_q        <= S_START;
          end
        end
        S_START, S_STREAM: begin
          if (remaining_q == '0) begin
            drain_cnt_q <= DW'(DRAIN_CYCLES - 1);
            state_q     <= S_DRAIN;
          end else begin
            state_q <= S_STREAM;
          end
        end
        S_DRAIN: begin
          if (drain_cnt_q == '0) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            drain_cnt_q <= drain_cnt_q - DW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign src_ready      = !in_full;
  assign glb2io_data    = glb2io_data_q;
  assign glb2io_start   = glb2io_start_q;
  assign snk_valid      = !out_empty;
  assign snk_data       = out_empty ? '0 : out_head[WW+NUM_CH-1:NUM_CH];
  assign snk_valid_mask = out_empty ? '0 : out_head[NUM_CH-1:0];
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign underrun       = underrun_q;
  assign overflow       = overflow_q;
  assign out_count      = out_count_q;
endmodule

// File: tb/tb_cgra_io_streamer.sv
// Directed bench for cgra_io_streamer: a 1x16 instance for the main scenarios
// and a 2x8 instance for per-channel valid masks.

module tb_cgra_io_streamer;
  localparam int DRAIN   = 64;
  localparam int B_DRAIN = 8;

  logic        io_clock;
  logic        io_reset;

  logic        start;
  logic [15:0] num_words;
  logic        src_valid;
  logic [15:0] src_data;
  logic        src_ready;
  logic [15:0] glb2io_data;
  logic        glb2io_start;
  logic [15:0] io2glb_data;
  logic [0:0]  io2glb_valid;
  logic        snk_valid;
  logic [15:0] snk_data;
  logic [0:0]  snk_valid_mask;
  logic        snk_ready;
  logic        busy;
  logic        done;
  logic        underrun;
  logic        overflow;
  logic [15:0] out_count;

  logic        loopback_en;
  logic [15:0] drv_data;
  logic        drv_valid;
  logic [15:0] lb_d1, lb_d2, lb_d3;

  logic        b_start;
  logic [7:0]  b_num_words;
  logic        b_src_valid;
  logic [15:0] b_src_data;
  logic        b_src_ready;
  logic [15:0] b_glb2io_data;
  logic        b_glb2io_start;
  logic [15:0] b_io2glb_data;
  logic [1:0]  b_io2glb_valid;
  logic        b_snk_valid;
  logic [15:0] b_snk_data;
  logic [1:0]  b_snk_valid_mask;
  logic        b_snk_ready;
  logic        b_busy;
  logic        b_done;
  logic        b_underrun;
  logic        b_overflow;
  logic [7:0]  b_out_count;

  int checks = 0;
  int errors = 0;

  cgra_io_streamer dut (
    .io_clock(io_clock), .io_reset(io_reset), .start(start), .num_words(num_words),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .glb2io_data(glb2io_data), .glb2io_start(glb2io_start),
    .io2glb_data(io2glb_data), .io2glb_valid(io2glb_valid),
    .snk_valid(snk_valid), .snk_data(snk_data), .snk_valid_mask(snk_valid_mask),
    .snk_ready(snk_ready), .busy(busy), .done(done), .underrun(underrun),
    .overflow(overflow), .out_count(out_count)
  );

  cgra_io_streamer #(
    .DATA_W(8), .NUM_CH(2), .FIFO_DEPTH(4), .LEN_W(8), .DRAIN_CYCLES(B_DRAIN)
  ) dut2 (
    .io_clock(io_clock), .io_reset(io_reset), .start(b_start), .num_words(b_num_words),
    .src_valid(b_src_valid), .src_data(b_src_data), .src_ready(b_src_ready),
    .glb2io_data(b_glb2io_data), .glb2io_start(b_glb2io_start),
    .io2glb_data(b_io2glb_data), .io2glb_valid(b_io2glb_valid),
    .snk_valid(b_snk_valid), .snk_data(b_snk_data), .snk_valid_mask(b_snk_valid_mask),
    .snk_ready(b_snk_ready), .busy(b_busy), .done(b_done), .underrun(b_underrun),
    .overflow(b_overflow), .out_count(b_out_count)
  );

  initial io_clock = 1'b0;
  always #5 io_clock = ~io_clock;

  // CGRA stand-in: echoes the stream back three cycles later.
  always @(posedge io_clock) begin
    lb_d1 <= glb2io_data;
    lb_d2 <= lb_d1;
    lb_d3 <= lb_d2;
  end
  assign io2glb_data  = loopback_en ? lb_d3 : drv_data;
  assign io2glb_valid = loopback_en ? (lb_d3 != 16'h0) : drv_valid;

  task automatic tick();
    @(posedge io_clock);
    #1;
  endtask

  task automatic preload(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      src_valid = 1'b1;
      src_data  = 16'(first + i);
      tick();
    end
    src_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge io_clock);
    #1;
    checks++; if (src_ready !== 1'b1) begin errors++; $display("FAIL reset_src_ready: got %b expected 1", src_ready); end
    checks++; if (glb2io_data !== 16'h0 || glb2io_start !== 1'b0) begin errors++; $display("FAIL reset_glb2io: got data=%h start=%b expected 0/0", glb2io_data, glb2io_start); end
    checks++; if ({busy, done, underrun, overflow, snk_valid} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {busy, done, underrun, overflow, snk_valid}); end
    checks++; if (out_count !== 16'h0 || snk_data !== 16'h0) begin errors++; $display("FAIL reset_counts: got out_count=%h snk_data=%h expected 0/0", out_count, snk_data); end
    io_reset = 1'b0;
    tick();
    $display("test_reset: done");
  endtask

  task automatic test_basic(input string tag);
    int n_done;
    int done_at;
    logic nonzero;
    preload(1, 4);
    num_words = 16'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (glb2io_start !== 1'b1) begin errors++; $display("FAIL %s_start_pulse: got %b expected 1", tag, glb2io_start); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (glb2io_data !== 16'(i)) begin errors++; $display("FAIL %s_word%0d: got %h expected %h", tag, i, glb2io_data, 16'(i)); end
      if (i == 1) begin
        checks++; if (glb2io_start !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL %s_start_one_cycle: got start=%b busy=%b expected 0/1", tag, glb2io_start, busy); end
      end
    end
    n_done = 0;
    done_at = -1;
    nonzero = 1'b0;
    for (int c = 1; c <= DRAIN + 8; c++) begin
      tick();
      if (glb2io_data !== 16'h0) nonzero = 1'b1;
      if (done === 1'b1) begin
        n_done++;
        if (done_at < 0) done_at = c;
      end
    end
    checks++; if (done_at != DRAIN + 1) begin errors++; $display("FAIL %s_done_latency: got %0d expected %0d", tag, done_at, DRAIN + 1); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL %s_done_width: got %0d expected 1", tag, n_done); end
    checks++; if (nonzero !== 1'b0) begin errors++; $display("FAIL %s_drain_zero: got nonzero data expected 0", tag); end
    checks++; if (underrun !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s_end_state: got underrun=%b busy=%b expected 0/0", tag, underrun, busy); end
    $display("test_basic(%s): done_at=%0d", tag, done_at);
  endtask

  task automatic test_underrun();
    logic [15:0] exp_w [5];
    int done_at;
    exp_w = '{16'd1, 16'd2, 16'd0, 16'd0, 16'd0};
    preload(1, 2);
    num_words = 16'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (glb2io_data !== exp_w[i]) begin errors++; $display("FAIL underrun_word%0d: got %h expected %h", i, glb2io_data, exp_w[i]); end
      if (i == 1) begin
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_early: got %b expected 0", underrun); end
      end
      if (i == 3) begin
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set: got %b expected 1", underrun); end
      end
    end
    done_at = -1;
    for (int c = 1; c <= DRAIN + 8 && done_at < 0; c++) begin
      tick();
      if (done === 1'b1) done_at = c;
    end
    checks++; if (done_at != DRAIN + 1) begin errors++; $display("FAIL underrun_done: got %0d expected %0d", done_at, DRAIN + 1); end
    $display("test_underrun: underrun=%b done_at=%0d", underrun, done_at);
  endtask

  task automatic test_loopback();
    int nxt;
    logic saw;
    preload(1, 8);
    checks++; if (src_ready !== 1'b0) begin errors++; $display("FAIL loop_full_ready: got %b expected 0", src_ready); end
    loopback_en = 1'b1;
    snk_ready = 1'b0;
    num_words = 16'd20;
    start = 1'b1;
    tick();
    start = 1'b0;
    nxt = 9;
    saw = 1'b0;
    for (int c = 0; c < 300 && !saw; c++) begin
      src_valid = (src_ready === 1'b1) && (nxt <= 20);
      src_data  = 16'(nxt);
      tick();
      if (src_valid) nxt++;
      if (done === 1'b1) saw = 1'b1;
    end
    src_valid = 1'b0;
    checks++; if (saw !== 1'b1) begin errors++; $display("FAIL loop_done_timeout: got no done expected done"); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL loop_overflow: got %b expected 1", overflow); end
    checks++; if (out_count !== 16'd20) begin errors++; $display("FAIL loop_out_count: got %0d expected 20", out_count); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL loop_underrun: got %b expected 0", underrun); end
    for (int k = 1; k <= 8; k++) begin
      checks++; if (snk_valid !== 1'b1 || snk_data !== 16'(k) || snk_valid_mask !== 1'b1) begin errors++; $display("FAIL loop_entry%0d: got v=%b d=%h m=%b expected 1/%h/1", k, snk_valid, snk_data, snk_valid_mask, 16'(k)); end
      snk_ready = 1'b1;
      tick();
      snk_ready = 1'b0;
    end
    checks++; if (snk_valid !== 1'b0) begin errors++; $display("FAIL loop_empty: got %b expected 0", snk_valid); end
    loopback_en = 1'b0;
    $display("test_loopback: out_count=%0d overflow=%b", out_count, overflow);
  endtask

  task automatic test_zero_len();
    int done_at;
    int pulses;
    logic nonzero;
    num_words = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (glb2io_start !== 1'b1) begin errors++; $display("FAIL zero_start: got %b expected 1", glb2io_start); end
    checks++; if (overflow !== 1'b0 || out_count !== 16'h0) begin errors++; $display("FAIL zero_cleared: got overflow=%b out_count=%0d expected 0/0", overflow, out_count); end
    done_at = -1;
    pulses = 0;
    nonzero = 1'b0;
    for (int c = 1; c <= DRAIN + 8 && done_at < 0; c++) begin
      tick();
      if (glb2io_start === 1'b1) pulses++;
      if (glb2io_data !== 16'h0) nonzero = 1'b1;
      if (done === 1'b1) done_at = c;
    end
    checks++; if (done_at != DRAIN + 1) begin errors++; $display("FAIL zero_done: got %0d expected %0d", done_at, DRAIN + 1); end
    checks++; if (pulses != 0 || nonzero !== 1'b0) begin errors++; $display("FAIL zero_no_data: got pulses=%0d nonzero=%b expected 0/0", pulses, nonzero); end
    checks++; if (out_count !== 16'h0) begin errors++; $display("FAIL zero_out_count: got %0d expected 0", out_count); end
    $display("test_zero_len: done_at=%0d", done_at);
  endtask

  task automatic test_multich();
    int done_at;
    for (int i = 0; i < 3; i++) begin
      b_src_valid = 1'b1;
      b_src_data  = 16'h0102 + 16'(i) * 16'h0202;
      tick();
    end
    b_src_valid = 1'b0;
    b_num_words = 8'd3;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    checks++; if (b_glb2io_start !== 1'b1) begin errors++; $display("FAIL mc_start: got %b expected 1", b_glb2io_start); end
    tick();
    checks++; if (b_glb2io_data !== 16'h0102) begin errors++; $display("FAIL mc_word0: got %h expected 0102", b_glb2io_data); end
    b_io2glb_valid = 2'b10;
    b_io2glb_data  = 16'hA55A;
    b_start = 1'b1;
    #1;
    checks++; if (b_snk_valid !== 1'b0) begin errors++; $display("FAIL mc_capture_latency: got %b expected 0", b_snk_valid); end
    tick();
    b_io2glb_valid = 2'b00;
    b_io2glb_data  = 16'h0;
    b_start = 1'b0;
    checks++; if (b_glb2io_data !== 16'h0304) begin errors++; $display("FAIL mc_word1: got %h expected 0304", b_glb2io_data); end
    tick();
    checks++; if (b_glb2io_data !== 16'h0506) begin errors++; $display("FAIL mc_word2: got %h expected 0506", b_glb2io_data); end
    done_at = -1;
    for (int c = 1; c <= B_DRAIN + 8 && done_at < 0; c++) begin
      tick();
      if (b_done === 1'b1) done_at = c;
    end
    checks++; if (done_at != B_DRAIN + 1) begin errors++; $display("FAIL mc_done: got %0d expected %0d", done_at, B_DRAIN + 1); end
    tick();
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL mc_idle_after: got %b expected 0", b_busy); end
    checks++; if (b_snk_valid !== 1'b1 || b_snk_data !== 16'hA55A || b_snk_valid_mask !== 2'b10) begin errors++; $display("FAIL mc_entry: got v=%b d=%h m=%b expected 1/a55a/10", b_snk_valid, b_snk_data, b_snk_valid_mask); end
    checks++; if (b_out_count !== 8'd1) begin errors++; $display("FAIL mc_out_count: got %0d expected 1", b_out_count); end
    b_snk_ready = 1'b1;
    tick();
    b_snk_ready = 1'b0;
    checks++; if (b_snk_valid !== 1'b0) begin errors++; $display("FAIL mc_popped: got %b expected 0", b_snk_valid); end
    $display("test_multich: done_at=%0d", done_at);
  endtask

  task automatic test_reset_mid_stream();
    logic saw_done;
    preload(1, 4);
    num_words = 16'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    drv_valid = 1'b1;
    drv_data  = 16'hBEEF;
    tick();
    drv_valid = 1'b0;
    drv_data  = 16'h0;
    checks++; if (snk_valid !== 1'b1 || glb2io_data !== 16'd2) begin errors++; $display("FAIL rst_pre: got snk_valid=%b data=%h expected 1/0002", snk_valid, glb2io_data); end
    #2;
    io_reset = 1'b1;
    #1;
    checks++; if (glb2io_data !== 16'h0 || glb2io_start !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_async_outputs: got data=%h start=%b busy=%b expected 0/0/0", glb2io_data, glb2io_start, busy); end
    checks++; if (snk_valid !== 1'b0 || src_ready !== 1'b1) begin errors++; $display("FAIL rst_fifos: got snk_valid=%b src_ready=%b expected 0/1", snk_valid, src_ready); end
    tick();
    io_reset = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < DRAIN + 8; c++) begin
      tick();
      if (done === 1'b1) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_no_done: got done_seen=%b busy=%b expected 0/0", saw_done, busy); end
    $display("test_reset_mid_stream: aborted run");
    test_basic("after_reset");
  endtask

  initial begin
    io_reset = 1'b1;
    start = 1'b0; num_words = '0; src_valid = 1'b0; src_data = '0; snk_ready = 1'b0;
    loopback_en = 1'b0; drv_data = '0; drv_valid = 1'b0;
    b_start = 1'b0; b_num_words = '0; b_src_valid = 1'b0; b_src_data = '0;
    b_io2glb_data = '0; b_io2glb_valid = '0; b_snk_ready = 1'b0;
    test_reset();
    test_basic("basic");
    test_underrun();
    test_loopback();
    test_zero_len();
    test_multich();
    test_reset_mid_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
